// File: rtl/ldl_fifo_pkg.sv
// Shared types and constants for the FWFT read adapter.
package ldl_fifo_pkg;

  // Read latency of the upstream FIFO port, in cycles.
  localparam int unsigned FWFT_RD_LAT = 1;

  // Output buffer occupancy; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_state_e;

endpackage

// File: rtl/ldl_fwft_buf2_v1.sv
// Two-entry register ring buffer: write pointer advances on push, head advances on pop.
module ldl_fwft_buf2_v1 #(
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] r_mem [2];
  logic          r_head;
  logic          r_tail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_din;
        r_tail        <= ~r_tail;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  // Output is selected among flops only; din never reaches it combinationally.
  assign o_data = r_mem[r_head];

endmodule

// File: rtl/ldl_fifo_fwft_v1.sv
// Converts a 1-cycle-latency FIFO read port into a first-word-fall-through valid/ready stream.
// Optional stall counter enabled by defining LDL_FIFO_FWFT_STAT_EN.
module ldl_fifo_fwft_v1
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned SKID = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_empty,
  output logic          o_re,
  input  logic [DW-1:0] i_din,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [DW-1:0] o_m_data,
  output logic [1:0]    o_occ
`ifdef LDL_FIFO_FWFT_STAT_EN
  ,
  output logic [15:0]   o_stall_cnt
`endif
);

  if (SKID != 2 || FWFT_RD_LAT != 1) begin : g_cfg_err
    $error("ldl_fifo_fwft_v1: only SKID=2 with a 1-cycle read latency is supported");
  end

  occ_state_e r_state;
  logic       r_inflight;
  logic       r_m_valid;
  logic       r_run;
  logic       w_pop;
  logic [2:0] w_level;

  assign w_pop   = r_m_valid & i_m_ready;
  // Projected occupancy after this cycle; pop implies occ >= 1 so no wrap.
  assign w_level = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
  // r_run holds re low from reset until the first edge after release.
  assign o_re    = r_run & ~i_empty & (w_level < 3'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S0;
      r_inflight <= 1'b0;
      r_m_valid  <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= o_re;
      unique case (r_state)
        S0: begin
          if (r_inflight) begin
            r_state   <= S1;
            r_m_valid <= 1'b1;
          end
        end
        S1: begin
          if (r_inflight && !w_pop) begin
            r_state <= S2;
          end else if (!r_inflight && w_pop) begin
            r_state   <= S0;
            r_m_valid <= 1'b0;
          end
        end
        S2: begin
          if (w_pop) begin
            r_state <= S1;
          end
        end
        default: begin
          r_state   <= S0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(r_state == S2 && r_inflight && !w_pop));

  ldl_fwft_buf2_v1 #(
    .DW (DW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_din   (i_din),
    .i_pop   (w_pop),
    .o_data  (o_m_data)
  );

  assign o_m_valid = r_m_valid;
  assign o_occ     = r_state;

`ifdef LDL_FIFO_FWFT_STAT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (r_m_valid && !i_m_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/ldl_fifo_fwft_v1.md
LDL_FIFO_FWFT_V1 -- requirements
Module: LDL_fifo_fwft_v1

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter SKID, default 2, output buffer depth; legal value 2 only (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 empty  input  1  FIFO read-side empty flag.
REQ-006 re  output  1  FIFO read strobe; FIFO data appears on din exactly 1 cycle after re.
REQ-007 din  input  DW  FIFO read data.
REQ-008 m_valid  output  1  stream valid.
REQ-009 m_ready  input  1  stream ready.
REQ-010 m_data  output  DW  stream data.
REQ-011 occ  output  2  words held in output buffer (0..2).

Function
REQ-012 Block SHALL convert a 1-cycle-latency FIFO read port into a first-word-fall-through valid/ready stream.
REQ-013 Definitions: pop = m_valid & m_ready; inflight = re registered 1 cycle.
REQ-014 re SHALL be combinational: re = !empty & ((occ + inflight - pop) < 2), in 2-bit-plus-carry arithmetic, no wrap.
REQ-015 Word read with re in cycle N SHALL be written to buffer at edge ending cycle N+1; m_valid may rise in cycle N+2.
REQ-016 Sustained throughput SHALL be 1 word/cycle when FIFO non-empty and m_ready held high.
REQ-017 m_valid SHALL equal (occ != 0); m_data SHALL be oldest buffered word, driven from a flop (no din-to-m_data comb path).
REQ-018 Occupancy FSM states: S0 (occ=0), S1 (occ=1), S2 (occ=2).
REQ-019 Transitions: S0->S1 on arrival; S1->S2 on arrival & !pop; S1->S0 on pop & !arrival; S1 stays on arrival & pop; S2->S1 on pop (no arrival possible in S2 without pop; REQ-014 guarantees).
REQ-020 Arrival into S2 without pop SHALL never occur; overflow is a design error flagged by assertion.
REQ-021 Order SHALL be strict FIFO; simultaneous arrival and pop in S1 SHALL output the new word next cycle.
REQ-022 Once m_valid is high, m_valid and m_data SHALL hold until pop (AXI-style stability).
REQ-023 m_ready SHALL have no combinational path to m_valid or m_data; it may affect re.
REQ-024 empty rising while inflight=1 SHALL not cancel the in-flight word.

Reset
REQ-025 rst low SHALL asynchronously set FSM=S0, occ=0, inflight=0, m_valid=0, m_data=0, re=0 (re gated by rst).
REQ-026 Reset mid-transfer SHALL discard buffered and in-flight words; the FIFO is reset in the same domain concurrently.
REQ-027 Deassertion SHALL be taken synchronous to clk (externally synchronized); first re no earlier than first edge after release.

Configuration
REQ-028 Macro LDL_FIFO_FWFT_STAT_EN defined: extra output stall_cnt [15:0], counts cycles with m_valid & !m_ready, saturates at 16'hFFFF, reset 0.
REQ-029 Macro undefined: stall_cnt port and counter SHALL not exist; remaining behaviour identical.

Structure
REQ-030 Package LDL_fifo_pkg SHALL hold the occupancy-state enum typedef (S0/S1/S2) and the constant FWFT_RD_LAT = 1.
REQ-031 One sub-module, LDL_fwft_buf2_v1: 2-entry register buffer with head pointer, push/pop, data out; FSM and re logic stay in the top.

Verification
REQ-032 FIFO holds 0x11,0x22,0x33, m_ready=1 -> re high cycles 0-2, m_valid cycles 2-4, m_data 0x11,0x22,0x33, no gaps.
REQ-033 FIFO holds 4 words, m_ready=0 -> exactly 2 re pulses, occ=2, re low thereafter; m_ready=1 -> words drain in order, re resumes same cycle as first pop.
REQ-034 m_ready toggles 1/0 each cycle, 16 words -> all 16 received in order, no loss/duplicate, occ never >2, m_data stable while stalled.
REQ-035 empty deasserts for one cycle only (single word) -> one re, m_valid high 2 cycles later, occ=1 until pop.
REQ-036 rst low while occ=2 and inflight=1 -> m_valid=0, occ=0, re=0 immediately; after release refill restarts cleanly.
REQ-037 With LDL_FIFO_FWFT_STAT_EN, m_valid=1 & m_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF held.
